// File: rtl/home_inventory_wbm.sv
// -----------------------------------------------------------------------------
// home_inventory_wbm
//   Wishbone classic initiator for the home-inventory register block.
//   Takes a request (address, data, sel, we, beat count) over valid/ready,
//   runs one single-beat ack-terminated Wishbone cycle per beat with the
//   address stepping by 4, and returns one response per beat over
//   valid/ready. An error (or timeout) ends the burst early.
//
//   Optional feature macro: HOME_INV_WBM_TIMEOUT_EN
//     defined   : a beat that sees no ack/err for TIMEOUT_CYCLES cycles is
//                 aborted as if wbm_err_i had been sampled.
//     undefined : the bus waits for ack/err indefinitely.
//
// Ports
//   wb_clk_i, wb_rst_ni                 clock, async active-low reset
//   req_valid_i/req_ready_o             request handshake (ready == idle)
//   req_we_i, req_adr_i, req_dat_i,
//   req_sel_i, req_len_i                request payload (len = beats - 1)
//   rsp_valid_o/rsp_ready_i             response handshake
//   rsp_dat_o, rsp_err_o, rsp_last_o    response payload
//   wbm_*                               Wishbone classic initiator port
//   busy_o                              not idle
// -----------------------------------------------------------------------------
module home_inventory_wbm #(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [31:0]      req_adr_i,
    input  logic [31:0]      req_dat_i,
    input  logic [3:0]       req_sel_i,
    input  logic [LEN_W-1:0] req_len_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_last_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic [31:0]      wbm_dat_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_last_q, rsp_last_d;
    logic               tmo_hit;

`ifdef HOME_INV_WBM_TIMEOUT_EN
    // At least 8 bits, wider only if TIMEOUT_CYCLES-1 does not fit.
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // tmo_q counts completed BUS cycles without ack/err, so it reads
    // TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th BUS cycle.
    assign tmo_hit = (state_q == BUS) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside BUS, which also clears it on every BUS entry.
    always_comb begin
        tmo_d = '0;
        if (state_q == BUS && !wbm_ack_i && !wbm_err_i && !tmo_hit)
            tmo_d = tmo_q + TMO_W'(1);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) tmo_q <= '0;
        else            tmo_q <= tmo_d;
    end
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES < 2);
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        len_d       = len_q;
        beat_d      = beat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    adr_d   = req_adr_i;
                    dat_d   = req_dat_i;
                    len_d   = req_len_i;
                    beat_d  = '0;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack has priority over err; timeout is the lowest.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    rsp_last_d  = (beat_q == len_q);
                    state_d     = RSP;
                end else if (wbm_err_i || tmo_hit) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = 32'h0;
                    rsp_last_d  = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        // Next beat goes out on the accepting edge.
                        adr_d   = adr_q + 32'd4;
                        beat_d  = beat_q + LEN_W'(1);
                        cyc_d   = 1'b1;
                        state_d = BUS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // cyc and stb always move together, so one flop drives both.
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_last_o  = rsp_last_q;
    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_home_inventory_wbm.sv
// -----------------------------------------------------------------------------
// tb_home_inventory_wbm
//   Drives home_inventory_wbm against a small Wishbone register-slave model
//   with random ack latency and error injection. Expected responses and bus
//   beats come from a request-level model (address arithmetic + register map).
// -----------------------------------------------------------------------------
module tb_home_inventory_wbm;
    localparam int LEN_W = 4;
    localparam int TMO   = 8;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_ni = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic             req_we_i = 1'b0;
    logic [31:0]      req_adr_i = '0;
    logic [31:0]      req_dat_i = '0;
    logic [3:0]       req_sel_i = '0;
    logic [LEN_W-1:0] req_len_i = '0;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic [31:0]      rsp_dat_o;
    logic             rsp_err_o;
    logic             rsp_last_o;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o, wbm_dat_o;
    logic             wbm_ack_i, wbm_err_i;
    logic [31:0]      wbm_dat_i;
    logic             busy_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    home_inventory_wbm #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .req_sel_i(req_sel_i), .req_len_i(req_len_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .rsp_last_o(rsp_last_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i),
        .busy_o(busy_o)
    );

    // ---------------- register slave model ----------------
    logic        ack_r, err_r;
    logic        spur_ack = 1'b0, spur_err = 1'b0, slv_mute = 1'b0;
    logic [31:0] rd_r = '0;
    logic [31:0] ctrl_q = '0;
    int lat_max = 0, cur_lat = 0, force_lat = -1, ack_wait = 0, slv_beat = 0, err_at = -1;

    assign wbm_ack_i = ack_r | spur_ack;
    assign wbm_err_i = err_r | spur_err;
    assign wbm_dat_i = rd_r;

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h4849_4348;
            32'h4:   return 32'h0000_0001;
            32'h100: return ctrl_q;
            default: return {a[15:0] ^ 16'h5A5A, a[31:16]};
        endcase
    endfunction

    always @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_r <= 1'b0; err_r <= 1'b0; ack_wait <= 0;
        end else begin
            ack_r <= 1'b0; err_r <= 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !ack_r && !err_r && !slv_mute) begin
                if (ack_wait < ((force_lat >= 0) ? force_lat : cur_lat)) begin
                    ack_wait <= ack_wait + 1;
                end else begin
                    ack_wait <= 0;
                    cur_lat  <= $urandom_range(lat_max, 0);
                    slv_beat <= slv_beat + 1;
                    if (slv_beat == err_at) begin
                        err_r <= 1'b1; rd_r <= $urandom;
                    end else begin
                        ack_r <= 1'b1;
                        if (wbm_we_o) begin
                            rd_r <= $urandom;
                            if (wbm_adr_o == 32'h100)
                                for (int b = 0; b < 4; b++)
                                    if (wbm_sel_o[b]) ctrl_q[b*8 +: 8] <= wbm_dat_o[b*8 +: 8];
                        end else begin
                            rd_r <= slv_rd(wbm_adr_o);
                        end
                    end
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } beat_t;

    beat_t beats_q[$];
    int    cyc_len_q[$];
    beat_t cur = '0;
    int    cyc_cnt = 0;
    int    bus_viol = 0;
    logic  prev_cyc = 1'b0;

    always @(negedge wb_clk_i) begin
        if (wbm_cyc_o !== wbm_stb_o || (wbm_cyc_o && rsp_valid_o)) bus_viol <= bus_viol + 1;
        if (wbm_cyc_o) begin
            if (!prev_cyc) begin
                cur <= {wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o};
                beats_q.push_back({wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o});
                cyc_cnt <= 1;
            end else begin
                if ({wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o} !== cur) bus_viol <= bus_viol + 1;
                cyc_cnt <= cyc_cnt + 1;
            end
        end else if (prev_cyc) begin
            cyc_len_q.push_back(cyc_cnt);
        end
        prev_cyc <= wbm_cyc_o;
    end

    // ---------------- request-level reference model ----------------
    logic [31:0] m_ctrl = '0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (a == 32'h0)   return 32'h4849_4348;
        if (a == 32'h4)   return 32'h0000_0001;
        if (a == 32'h100) return m_ctrl;
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    // Issue one request, collect and check every response (with random
    // backpressure up to bp cycles), then check the beats seen on the bus.
    // eb = index of the beat the slave errors (-1: none).
    task automatic run_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int len, input int eb, input int bp);
        int n, base, t, h;
        logic [31:0] a, ed;
        logic ee, el;
        beat_t bt;
        n = (eb >= 0 && eb <= len) ? eb + 1 : len + 1;
        base = beats_q.size();
        t = 0;
        while (req_ready_o !== 1'b1 && t < 100) begin @(negedge wb_clk_i); t++; end
        n_chk++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL req_ready wait: got %b required 1", req_ready_o); return;
        end
        err_at = (eb >= 0) ? slv_beat + eb : -1;
        req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
        req_len_i = LEN_W'(len); req_valid_i = 1'b1;
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = adr + 32'(4 * i);
            if (i == eb) begin
                ed = 32'h0; ee = 1'b1; el = 1'b1;
            end else begin
                ee = 1'b0; el = (i == len);
                ed = we ? 32'h0 : ref_rd(a);
                if (we && a == 32'h100)
                    for (int b = 0; b < 4; b++) if (sel[b]) m_ctrl[b*8 +: 8] = dat[b*8 +: 8];
            end
            t = 0;
            while (rsp_valid_o !== 1'b1 && t < 400) begin @(negedge wb_clk_i); t++; end
            n_chk++;
            if (rsp_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL rsp_wait beat %0d: rsp_valid=%b required 1", i, rsp_valid_o);
                return;
            end
            n_chk++;
            if ({rsp_dat_o, rsp_err_o, rsp_last_o} !== {ed, ee, el}) begin
                n_fail++;
                $display("FAIL rsp beat %0d adr %h: dat/err/last=%h/%b/%b required %h/%b/%b",
                         i, a, rsp_dat_o, rsp_err_o, rsp_last_o, ed, ee, el);
            end
            h = $urandom_range(bp, 0);
            for (int k = 0; k < h; k++) begin
                @(negedge wb_clk_i);
                n_chk++;
                if ({rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o, wbm_cyc_o} !== {1'b1, ed, ee, el, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rsp_hold beat %0d: valid/dat/err/last/cyc=%b/%h/%b/%b/%b required 1/%h/%b/%b/0",
                             i, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o, wbm_cyc_o, ed, ee, el);
                end
            end
            rsp_ready_i = 1'b1;
            @(negedge wb_clk_i);
            rsp_ready_i = 1'b0;
        end
        n_chk++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL busy_after_last: got %b required 0", busy_o);
        end
        n_chk++;
        if (beats_q.size() - base != n) begin
            n_fail++; $display("FAIL beat_count: got %0d required %0d", beats_q.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                bt = beats_q[base + i];
                n_chk++;
                if (bt !== beat_t'({adr + 32'(4 * i), dat, we, sel})) begin
                    n_fail++;
                    $display("FAIL bus_beat %0d: adr/dat/we/sel=%h/%h/%b/%h required %h/%h/%b/%h",
                             i, bt.adr, bt.dat, bt.we, bt.sel, adr + 32'(4 * i), dat, we, sel);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wb_rst_ni = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        n_chk++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
             rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: cyc=%b adr=%h dat=%h rsp_valid=%b rsp_dat=%h required all 0",
                     wbm_cyc_o, wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_dat_o);
        end
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        n_chk++;
        if ({req_ready_o, busy_o} !== 2'b10) begin
            n_fail++; $display("FAIL reset_ready: ready/busy=%b/%b required 1/0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_single_read();
        run_req(1'b0, 32'h0, 32'h0, 4'hF, 0, -1, 0);
        n_chk++;
        if (cyc_len_q.size() == 0 || cyc_len_q[$] != 2) begin
            n_fail++; $display("FAIL single_read_cyc_len: got %0d required 2",
                               (cyc_len_q.size() == 0) ? -1 : cyc_len_q[$]);
        end
    endtask

    task automatic test_write();
        run_req(1'b1, 32'h100, 32'h1, 4'hF, 0, -1, 0);
        n_chk++;
        if (ctrl_q !== 32'h1) begin
            n_fail++; $display("FAIL write_ctrl: slave ctrl=%h required 00000001", ctrl_q);
        end
        run_req(1'b0, 32'h100, 32'h0, 4'hF, 0, -1, 0);
    endtask

    task automatic test_burst();
        run_req(1'b0, 32'h0, 32'h0, 4'hF, 1, -1, 0);
    endtask

    task automatic test_backpressure();
        int t;
        req_we_i = 1'b0; req_adr_i = 32'h0; req_dat_i = 32'h0; req_sel_i = 4'hF;
        req_len_i = LEN_W'(1); req_valid_i = 1'b1;
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
        t = 0;
        while (rsp_valid_o !== 1'b1 && t < 50) begin @(negedge wb_clk_i); t++; end
        for (int k = 0; k < 5; k++) begin
            spur_ack = (k == 2);
            @(negedge wb_clk_i);
            n_chk++;
            if ({rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o, wbm_cyc_o, wbm_stb_o} !==
                {1'b1, 32'h4849_4348, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold %0d: valid/dat/err/last/cyc=%b/%h/%b/%b/%b required 1/48494348/0/0/0",
                         k, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o, wbm_cyc_o);
            end
        end
        spur_ack = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        n_chk++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_adr_o, rsp_valid_o} !== {1'b1, 1'b1, 32'h4, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_next_beat: cyc/stb/adr/valid=%b/%b/%h/%b required 1/1/00000004/0",
                     wbm_cyc_o, wbm_stb_o, wbm_adr_o, rsp_valid_o);
        end
        t = 0;
        while (rsp_valid_o !== 1'b1 && t < 50) begin @(negedge wb_clk_i); t++; end
        n_chk++;
        if ({rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o} !== {1'b1, 32'h1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_beat1: valid/dat/err/last=%b/%h/%b/%b required 1/00000001/0/1",
                     rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_idle_spurious();
        spur_ack = 1'b1; spur_err = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        spur_ack = 1'b0; spur_err = 1'b0;
        @(negedge wb_clk_i);
        n_chk++;
        if ({busy_o, rsp_valid_o, wbm_cyc_o} !== 3'b000) begin
            n_fail++; $display("FAIL idle_spurious: busy/valid/cyc=%b/%b/%b required 0/0/0",
                               busy_o, rsp_valid_o, wbm_cyc_o);
        end
    endtask

    task automatic test_error();
        run_req(1'b0, 32'h10, 32'h0, 4'hF, 5, 2, 2);
        run_req(1'b0, 32'h40, 32'h0, 4'hF, 3, 0, 0);
        run_req(1'b1, 32'h0F8, 32'hCAFE_F00D, 4'h3, 4, 3, 1);
    endtask

    task automatic test_wrap();
        run_req(1'b0, 32'hFFFF_FFF8, 32'h0, 4'hF, 2, -1, 1);
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] adr;
        int          len, eb;
        for (int r = 0; r < 30; r++) begin
            lat_max = $urandom_range(3, 0);
            we  = $urandom_range(1, 0);
            adr = 32'($urandom_range(127, 0)) << 2;
            len = $urandom_range(7, 0);
            eb  = ($urandom_range(3, 0) == 0) ? $urandom_range(len, 0) : -1;
            run_req(we, adr, $urandom, 4'($urandom_range(15, 0)), len, eb, 3);
        end
        lat_max = 0;
    endtask

`ifdef HOME_INV_WBM_TIMEOUT_EN
    task automatic test_timeout();
        slv_mute = 1'b1;
        run_req(1'b0, 32'h20, 32'h0, 4'hF, 3, 0, 2);
        slv_mute = 1'b0;
        n_chk++;
        if (cyc_len_q[$] != TMO) begin
            n_fail++; $display("FAIL timeout_cyc_len: got %0d required %0d", cyc_len_q[$], TMO);
        end
        // Ack landing in the last allowed cycle is a normal completion.
        force_lat = TMO - 2;
        run_req(1'b0, 32'h44, 32'h0, 4'hF, 0, -1, 0);
        n_chk++;
        if (cyc_len_q[$] != TMO) begin
            n_fail++; $display("FAIL ack_final_cyc_len: got %0d required %0d", cyc_len_q[$], TMO);
        end
        // One cycle later is too late.
        force_lat = TMO - 1;
        run_req(1'b0, 32'h48, 32'h0, 4'hF, 0, 0, 0);
        force_lat = -1;
        repeat (2) @(negedge wb_clk_i);
    endtask
`else
    task automatic test_timeout();
        force_lat = 20;
        run_req(1'b0, 32'h44, 32'h0, 4'hF, 0, -1, 0);
        force_lat = -1;
        n_chk++;
        if (cyc_len_q[$] != 22) begin
            n_fail++; $display("FAIL long_wait_cyc_len: got %0d required 22", cyc_len_q[$]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int t;
        slv_mute = 1'b1;
        req_we_i = 1'b0; req_adr_i = 32'h8; req_sel_i = 4'hF;
        req_len_i = LEN_W'(2); req_valid_i = 1'b1;
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
        t = 0;
        while (wbm_stb_o !== 1'b1 && t < 20) begin @(negedge wb_clk_i); t++; end
        #2 wb_rst_ni = 1'b0;
        #1;
        n_chk++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_async: cyc/stb/valid=%b/%b/%b required 0/0/0",
                               wbm_cyc_o, wbm_stb_o, rsp_valid_o);
        end
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        slv_mute = 1'b0;
        @(negedge wb_clk_i);
        n_chk++;
        if ({req_ready_o, busy_o} !== 2'b10) begin
            n_fail++; $display("FAIL reset_mid_ready: ready/busy=%b/%b required 1/0", req_ready_o, busy_o);
        end
        run_req(1'b0, 32'h4, 32'h0, 4'hF, 0, -1, 0);
    endtask

    task automatic test_bus_rules();
        n_chk++;
        if (bus_viol != 0) begin
            n_fail++; $display("FAIL bus_rules: %0d violations required 0", bus_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_burst();
        test_backpressure();
        test_idle_spurious();
        test_error();
        test_wrap();
        test_timeout();
        test_random();
        test_reset_mid();
        test_bus_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/home_inventory_wbm.md
Name: home_inventory_wbm

Overview:
Wishbone classic initiator for the home-inventory register block. It drives the same single-beat, ack-terminated protocol the register slave implements.
- Accepts a request (address, data, sel, we, beat count) over a valid/ready handshake.
- Issues one Wishbone cycle per beat, auto-incrementing the address by 4 between beats.
- Returns one response per beat (read data, error, last) over a valid/ready handshake.
- Used by the on-chip sequencer and by the bring-up bench as the bus driver.

Parameters:
LEN_W, 4, width of req_len_i; a burst is req_len_i+1 beats, max 2^LEN_W.
TIMEOUT_CYCLES, 255, maximum cycles cyc/stb stay high per beat before abort. Used only with the optional feature; must be >=2.

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high with req_valid_i
req_we_i  in  1  1=write, 0=read
req_adr_i  in  32  start byte address, word aligned
req_dat_i  in  32  write data, replicated on every beat
req_sel_i  in  4  byte strobes, applied on every beat
req_len_i  in  LEN_W  beats minus one
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_dat_o  out  32  read data (0 for writes and errors)
rsp_err_o  out  1  beat ended by wbm_err_i or timeout
rsp_last_o  out  1  final response of the request
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  4  Wishbone byte select
wbm_adr_o  out  32  Wishbone address
wbm_dat_o  out  32  Wishbone write data
wbm_ack_i  in  1  Wishbone ack
wbm_err_i  in  1  Wishbone error (tie 0 if unused)
wbm_dat_i  in  32  Wishbone read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, wb_rst_ni=0):
  - State=IDLE.
  - All registered outputs are 0: cyc, stb, we, sel, adr, dat, rsp_*.
  - cyc/stb drop immediately, even mid-beat.
  - req_ready_o=1 once reset is released.
- All Wishbone and response outputs are registered. req_ready_o = (state==IDLE). busy_o = !req_ready_o.
- IDLE:
  - On req_valid_i & req_ready_o at edge N: latch adr/dat/sel/we/len, clear beat counter, go BUS.
  - cyc=stb=1 from edge N.
- BUS:
  - cyc/stb/we/sel/adr/dat held constant.
  - At first edge M where wbm_ack_i=1: capture wbm_dat_i (reads) into rsp_dat_o, rsp_err_o=0, drop cyc/stb, set rsp_valid_o, go RSP.
  - wbm_err_i=1 (ack takes priority if both are set): drop cyc/stb, rsp_err_o=1, rsp_dat_o=0, rsp_last_o=1, go RSP.
  - A Wishbone cycle for a beat therefore lasts (M-N) cycles; the response appears the cycle after the ack is sampled.
- RSP:
  - cyc/stb=0; backpressure never holds the bus.
  - rsp_last_o = (beat==len) | rsp_err_o.
  - Response outputs are stable until rsp_ready_i.
  - On accept: if last, go IDLE and clear rsp_valid_o. Otherwise adr+=4 (mod 2^32, wraps 0xFFFF_FFFC→0), beat+=1, go BUS; cyc/stb reassert on that same edge.
- Error aborts the remainder of the burst. No further beats are issued.
- wbm_ack_i/wbm_err_i are ignored outside BUS.
- req_valid_i is ignored while busy.
- Writes: rsp_dat_o=0.

Optional Feature:
HOME_INV_WBM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on BUS entry and increments each BUS cycle without ack/err.
  - If no ack/err is seen by the TIMEOUT_CYCLES-th BUS cycle, treat it as wbm_err_i: cyc/stb are high exactly TIMEOUT_CYCLES cycles, then rsp_err_o=1, rsp_last_o=1, rsp_dat_o=0.
  - An ack arriving on the final cycle wins over the timeout.
- Undefined: no counter; BUS waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Single read of 0x0000_0000, len=0, connected to the register slave → one response: dat=0x4849_4348, err=0, last=1; cyc high only until the ack edge; busy_o back to 0 the cycle after the response is accepted.
- Write 0x0000_0100, dat=0x1, sel=0xF → slave ctrl_enable=1; one response with dat=0, err=0, last=1.
- Burst read 0x0000_0000, len=1 → adr 0x0 then 0x4; responses 0x4849_4348 (last=0) then 0x0000_0001 (last=1); cyc low between beats.
- Backpressure: rsp_ready_i low 5 cycles on beat 0 of a 2-beat read → rsp_* held stable, cyc=0 throughout, beat 1 starts the edge after the accept.
- Timeout (macro defined, TIMEOUT_CYCLES=8, ack tied 0), read len=3 → cyc/stb high exactly 8 cycles; single response err=1, last=1, dat=0; no further beats. Repeat with wbm_err_i pulse → same response.
- Reset mid-beat: drop wb_rst_ni while stb=1 → cyc/stb/rsp_valid_o go 0 without a clock edge; after release req_ready_o=1 and a fresh read of 0x4 returns 0x0000_0001.
